// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//
// Round-robin write arbiter that lets NUM_REQ requesters share one FIFO write
// port. A requester owns the port from grant until it sends a beat flagged
// with req_last, or until it has sent MAX_BURST beats, whichever comes first.
// After every grant the arbiter spends exactly one cycle in IDLE, where it
// picks the next owner starting from the requester after the previous owner.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous clear of all arbiter state (outputs gated at once)
//   req_vld     per-requester data valid
//   req_last    per-requester end-of-packet marker, qualified by req_vld
//   req_data    packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_rdy     per-requester ready (only the owner can see fifo_rdy)
//   fifo_rdy    FIFO write-side ready
//   fifo_afull  FIFO almost-full; blocks new grants only
//   fifo_vld    write valid to the FIFO
//   fifo_data   write data to the FIFO
//   grant_id    index of the current owner, 0 when idle
//   busy        high while a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic                          fifo_rdy,
    input  logic                          fifo_afull,
    output logic                          fifo_vld,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    // One extra bit so rr_ptr + offset can be wrapped without overflow.
    localparam logic [ID_W:0]      NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   CAP_CNT   = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]   grant_reg, grant_next;
    logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;

    // Unpacked view of the requester data bus for a clean owner mux.
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first set req_vld at or after rr_ptr, wrapping.
    // The loop runs from the farthest offset down so the nearest one wins.
    // -----------------------------------------------------------------------
    logic            pick_vld;
    logic [ID_W-1:0] pick_id;

    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        sum      = '0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_reg} + (ID_W + 1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[ID_W-1:0];
            if (req_vld[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Beat and release qualification. flush masks the port in the same
    // cycle, so a beat presented alongside flush never counts as transferred.
    // -----------------------------------------------------------------------
    logic active;
    logic owner_vld;
    logic owner_last;
    logic beat;
    logic rel;

    assign active     = (state_reg == XFER) && !flush;
    assign owner_vld  = req_vld[grant_reg];
    assign owner_last = req_last[grant_reg];
    assign beat       = active && owner_vld && fifo_rdy;
    assign rel        = beat && (owner_last || (beat_cnt_reg == CAP_CNT));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_reg    <= grant_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_next    = grant_reg;
        beat_cnt_next = beat_cnt_reg;
        if (flush) begin
            state_next    = IDLE;
            rr_ptr_next   = '0;
            grant_next    = '0;
            beat_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // almost-full only gates new grants, never an active one
                    if (!fifo_afull && pick_vld) begin
                        state_next    = XFER;
                        grant_next    = pick_id;
                        beat_cnt_next = '0;
                    end
                end
                XFER: begin
                    if (rel) begin
                        state_next    = IDLE;
                        rr_ptr_next   = (grant_reg == LAST_ID) ? '0 : grant_reg + ID_W'(1);
                        // grant_id reads 0 whenever no one owns the port
                        grant_next    = '0;
                        beat_cnt_next = '0;
                    end else if (beat) begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (combinational from state and owner inputs)
    // -----------------------------------------------------------------------
    always_comb begin
        busy      = (state_reg == XFER);
        grant_id  = grant_reg;
        fifo_vld  = active && owner_vld;
        fifo_data = data_arr[grant_reg];
        req_rdy   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy[i] = active && fifo_rdy && (grant_reg == ID_W'(i));
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
//
// Bench for fifo_wr_arb with 4 requesters, 32-bit data and MAX_BURST=8.
// A vector table covers round-robin order, almost-full gating and owner
// valid drop; hand-written sequences cover burst cap, backpressure, flush
// and asynchronous reset. Every FIFO write is checked against a queue of
// expected words pushed when the stimulus is set up.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NR-1:0]     req_vld = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_rdy;
    logic              fifo_rdy = 1'b0;
    logic              fifo_afull = 1'b0;
    logic              fifo_vld;
    logic [DW-1:0]     fifo_data;
    logic [IW-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_vld    (req_vld),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_rdy    (req_rdy),
        .fifo_rdy   (fifo_rdy),
        .fifo_afull (fifo_afull),
        .fifo_vld   (fifo_vld),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted FIFO write must match the next expected word.
    always @(negedge clk) begin
        if (fifo_vld && fifo_rdy) begin
            $display("[TB] t=%0t write data=%h grant=%0d", $time, fifo_data, grant_id);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got write %h, expected no write", fifo_data);
            end else begin
                check("sb_write", fifo_data, sb_q.pop_front());
            end
        end
    end

    // -----------------------------------------------------------------------
    // Requester model for the hand-written sequences
    // -----------------------------------------------------------------------
    int       rem [NR];
    int       len [NR];
    bit       use_last [NR];
    logic [7:0] tag = 8'h00;

    function automatic logic [DW-1:0] mkd(input int i, input int pos);
        return {8'(i), tag, 16'(pos)};
    endfunction

    task automatic load(input int i, input int n, input bit ul);
        rem[i]      = n;
        len[i]      = n;
        use_last[i] = ul;
    endtask

    task automatic push_exp(input int i, input int pos);
        sb_q.push_back(mkd(i, pos));
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_vld[i]              = (rem[i] > 0);
            req_last[i]             = use_last[i] && (rem[i] == 1);
            req_data[i*DW +: DW]    = mkd(i, len[i] - rem[i]);
        end
    endtask

    task automatic advance(input logic [NR-1:0] hs);
        for (int i = 0; i < NR; i++) begin
            if (hs[i] && rem[i] > 0) rem[i]--;
        end
    endtask

    // One clock: drive model, check outputs at negedge, advance on handshakes.
    task automatic step_check(input string nm, input logic eb, input logic [IW-1:0] eg,
                              input logic ev, input logic [NR-1:0] er);
        logic [NR-1:0] hs;
        drive_reqs();
        @(negedge clk);
        check(nm, 32'({busy, grant_id, fifo_vld, req_rdy}), 32'({eb, eg, ev, er}));
        if (ev) check({nm, "_data"}, fifo_data, mkd(int'(eg), len[eg] - rem[eg]));
        hs = req_vld & req_rdy;
        @(posedge clk);
        #1;
        advance(hs);
    endtask

    // Requester 3 sends a 4-beat packet; beat 2 is hit by flush or reset.
    // Requester 0 then shows up alongside to prove rr_ptr went back to 0.
    task automatic flush_or_reset(input bit use_rst);
        logic [NR-1:0] hs;
        string         pfx;
        pfx = use_rst ? "rst" : "flush";
        tag = use_rst ? 8'h04 : 8'h03;
        // 1-beat packet on requester 0 so rr_ptr is 1 before the test
        load(0, 1, 1'b1);
        push_exp(0, 0);
        step_check({pfx, "_pre_idle"}, 1'b0, 2'd0, 1'b0, 4'b0000);
        step_check({pfx, "_pre_x"},    1'b1, 2'd0, 1'b1, 4'b0001);
        load(3, 4, 1'b1);
        push_exp(3, 0);
        step_check({pfx, "_c0"}, 1'b0, 2'd0, 1'b0, 4'b0000);
        step_check({pfx, "_c1"}, 1'b1, 2'd3, 1'b1, 4'b1000);
        drive_reqs();
        if (use_rst) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_async", 32'({busy, fifo_vld, req_rdy}), 32'd0);
        end else begin
            flush = 1'b1;
        end
        @(negedge clk);
        if (use_rst) check("rst_cycle", 32'({busy, grant_id, fifo_vld, req_rdy}), 32'd0);
        else         check("flush_cycle", 32'({busy, grant_id, fifo_vld, req_rdy}),
                           32'({1'b1, 2'd3, 1'b0, 4'b0000}));
        hs = req_vld & req_rdy;
        @(posedge clk);
        #1;
        advance(hs);
        flush = 1'b0;
        rst_n = 1'b1;
        load(0, 1, 1'b1);
        push_exp(0, 0);
        for (int k = 1; k < 4; k++) push_exp(3, k);
        step_check({pfx, "_c3_idle"}, 1'b0, 2'd0, 1'b0, 4'b0000);
        step_check({pfx, "_c4_g0"},   1'b1, 2'd0, 1'b1, 4'b0001);
        step_check({pfx, "_c5_idle"}, 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int c = 6; c <= 8; c++)
            step_check($sformatf("%s_c%0d_g3", pfx, c), 1'b1, 2'd3, 1'b1, 4'b1000);
        step_check({pfx, "_c9_idle"}, 1'b0, 2'd0, 1'b0, 4'b0000);
    endtask

    // -----------------------------------------------------------------------
    // Vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic [NR-1:0] vld;
        logic [NR-1:0] last;
        logic          frdy;
        logic          afull;
        logic          eb;
        logic [IW-1:0] eg;
        logic          ev;
        logic [NR-1:0] er;
    } tv_t;

    localparam int NV = 28;
    tv_t tv [NV];

    function automatic tv_t mk(input logic [NR-1:0] v, input logic [NR-1:0] l,
                               input logic fr, input logic af, input logic eb,
                               input logic [IW-1:0] eg, input logic ev, input logic [NR-1:0] er);
        tv_t t;
        t.vld = v; t.last = l; t.frdy = fr; t.afull = af;
        t.eb = eb; t.eg = eg; t.ev = ev; t.er = er;
        return t;
    endfunction

    initial begin
        //            vld      last     rdy   afull  busy gid   fvld  req_rdy
        // single requester 2, 3 beats, release leaves rr_ptr=3
        tv[0]  = mk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[1]  = mk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);
        tv[2]  = mk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);
        tv[3]  = mk(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);
        // rr_ptr=3 with 2 and 3 requesting must pick 3
        tv[4]  = mk(4'b1100, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[5]  = mk(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);
        // almost-full blocks grants in IDLE, then ignored during XFER
        tv[6]  = mk(4'b0011, 4'b0011, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[7]  = mk(4'b0011, 4'b0011, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[8]  = mk(4'b0011, 4'b0011, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[9]  = mk(4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[10] = mk(4'b0011, 4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001);
        // rr_ptr=1: only 3 requesting, then rr_ptr returns to 0
        tv[11] = mk(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[12] = mk(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);
        // all requesting, 1-beat packets: 0,1,2,3,0 with an IDLE between
        tv[13] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[14] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
        tv[15] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[16] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010);
        tv[17] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[18] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);
        tv[19] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[20] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);
        tv[21] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[22] = mk(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
        // owner drops valid mid-grant: grant held, ready follows fifo_rdy
        tv[23] = mk(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tv[24] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010);
        tv[25] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);
        tv[26] = mk(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010);
        tv[27] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---- reset state, with requests and fifo_rdy already high ----
        rst_n    = 1'b0;
        req_vld  = 4'b1111;
        req_last = 4'b1111;
        fifo_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'({busy, grant_id, fifo_vld, req_rdy}), 32'd0);
        rst_n = 1'b1;

        // ---- table-driven vectors ----
        for (int r = 0; r < NV; r++) begin
            req_vld    = tv[r].vld;
            req_last   = tv[r].last;
            fifo_rdy   = tv[r].frdy;
            fifo_afull = tv[r].afull;
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {8'(i), 8'hEE, 16'(r)};
            if (tv[r].ev && tv[r].frdy) sb_q.push_back({8'(tv[r].eg), 8'hEE, 16'(r)});
            @(negedge clk);
            check($sformatf("vec%0d", r), 32'({busy, grant_id, fifo_vld, req_rdy}),
                  32'({tv[r].eb, tv[r].eg, tv[r].ev, tv[r].er}));
            @(posedge clk);
            #1;
        end
        fifo_afull = 1'b0;
        fifo_rdy   = 1'b1;

        // ---- burst cap: requester 1 streams 20 beats without last ----
        tag = 8'h01;
        load(1, 20, 1'b0);
        for (int k = 0; k < 20; k++) push_exp(1, k);
        for (int c = 0; c < 24; c++) begin
            logic eb;
            eb = !(c == 0 || c == 9 || c == 18);
            step_check($sformatf("burst_c%0d", c), eb, eb ? 2'd1 : 2'd0,
                       eb && (c <= 22), eb ? 4'b0010 : 4'b0000);
        end
        // stuck in XFER with no last pending; flush clears it
        flush = 1'b1;
        step_check("burst_flush", 1'b1, 2'd1, 1'b0, 4'b0000);
        flush = 1'b0;
        step_check("burst_post", 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---- backpressure: 5-cycle stall after beat 1 of a 4-beat packet ----
        tag = 8'h02;
        load(0, 4, 1'b1);
        for (int k = 0; k < 4; k++) push_exp(0, k);
        step_check("bp_c0", 1'b0, 2'd0, 1'b0, 4'b0000);
        step_check("bp_c1", 1'b1, 2'd0, 1'b1, 4'b0001);
        fifo_rdy = 1'b0;
        for (int c = 2; c <= 6; c++)
            step_check($sformatf("bp_stall%0d", c), 1'b1, 2'd0, 1'b1, 4'b0000);
        fifo_rdy = 1'b1;
        for (int c = 7; c <= 9; c++)
            step_check($sformatf("bp_c%0d", c), 1'b1, 2'd0, 1'b1, 4'b0001);
        step_check("bp_c10_idle", 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---- flush, then the same with an asynchronous reset pulse ----
        flush_or_reset(1'b0);
        flush_or_reset(1'b1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, meaning data width of each requester and of the FIFO write port.
REQ-003 Parameter MAX_BURST, default 8, meaning max beats per grant before forced release (1..255).
REQ-004 Parameter CNT_W, default ceilLog2(MAX_BURST+1), meaning beat-counter width (derived, not overridden).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous clear of arbiter state.
REQ-008 req_vld  input  NUM_REQ  per-requester data valid.
REQ-009 req_last  input  NUM_REQ  per-requester end-of-packet marker, qualified by req_vld.
REQ-010 req_data  input  NUM_REQ*DATA_WIDTH  packed requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 req_rdy  output  NUM_REQ  per-requester ready.
REQ-012 fifo_rdy  input  1  FIFO write-side ready.
REQ-013 fifo_afull  input  1  FIFO almost-full flag.
REQ-014 fifo_vld  output  1  write valid to the FIFO.
REQ-015 fifo_data  output  DATA_WIDTH  write data to the FIFO.
REQ-016 grant_id  output  ceilLog2(NUM_REQ)  index of the current owner; 0 when idle.
REQ-017 busy  output  1  high while in XFER.

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE and XFER.
REQ-019 In IDLE with fifo_afull=0 and any req_vld set, the FSM SHALL select the first set req_vld at or after rr_ptr (modulo NUM_REQ), latch it into grant_id, clear beat_cnt, and enter XFER on the next edge.
REQ-020 In IDLE with fifo_afull=1, no grant SHALL be issued, regardless of req_vld.
REQ-021 In IDLE, fifo_vld and all req_rdy bits SHALL be 0.
REQ-022 In XFER, the output signals SHALL be combinational, as follows:
- fifo_vld = req_vld[grant_id];
- fifo_data = req_data slice of grant_id;
- req_rdy[grant_id] = fifo_rdy;
- all other req_rdy bits = 0.
REQ-023 A beat SHALL transfer when fifo_vld & fifo_rdy; each beat increments beat_cnt by 1.
REQ-024 Release SHALL occur on the edge of a transferring beat with req_last=1, or with beat_cnt = MAX_BURST-1.
REQ-025 On release, the FSM SHALL return to IDLE and set rr_ptr = (grant_id+1) modulo NUM_REQ.
REQ-026 Every grant SHALL be followed by exactly one IDLE cycle; minimum spacing between grants is 1 cycle.
REQ-027 In XFER, deassertion of req_vld by the owner SHALL NOT release the grant; the FSM holds until release.
REQ-028 In XFER, fifo_afull SHALL NOT stall or release the grant; backpressure is via fifo_rdy only.
REQ-029 Beats without req_last are unbounded in packet terms; MAX_BURST caps ownership; the next beats of the same requester re-arbitrate normally.
REQ-030 fifo_vld SHALL never be asserted with fifo_rdy ignored; data and valid SHALL remain stable while fifo_vld=1 and fifo_rdy=0, provided the requester holds its inputs stable.
REQ-031 flush=1 SHALL, on the next edge, force IDLE, rr_ptr=0, beat_cnt=0 and grant_id=0; flush overrides any transferring beat in the same cycle.
REQ-032 While flush=1, fifo_vld and req_rdy SHALL be forced to 0 combinationally.

Reset
REQ-033 rst_n=0 SHALL asynchronously set FSM=IDLE, rr_ptr=0, beat_cnt=0 and grant_id=0.
REQ-034 While rst_n=0, busy=0, fifo_vld=0 and req_rdy=0.
REQ-035 Reset assertion mid-XFER SHALL abort the grant immediately; no partial-beat state is retained.

Verification
REQ-036 Single-requester round-robin: req_vld=4'b0100, 3 beats with last on beat 3, fifo_rdy=1.
- grant_id=2 from cycle 2;
- 3 fifo writes in order;
- IDLE on cycle 5;
- rr_ptr=3.
REQ-037 All-requesting round-robin: req_vld=4'b1111 continuously, each packet 1 beat with last.
- grant order is 0,1,2,3,0;
- one IDLE cycle between grants.
REQ-038 Burst cap: MAX_BURST=8, requester 1 streams 20 beats with no last.
- release after beat 8;
- with only requester 1 active, re-grant to 1 after 1 IDLE cycle;
- all 20 beats delivered in order.
REQ-039 Backpressure stall: requester 0, fifo_rdy=0 for 5 cycles in mid-packet.
- fifo_vld and fifo_data stay stable;
- beat_cnt does not advance;
- req_rdy[0]=0 during the stall.
REQ-040 Almost-full gating: fifo_afull=1 in IDLE with req_vld=4'b0011.
- no grant while afull=1;
- grant to requester 0 one cycle after afull falls.
REQ-041 Flush and reset mid-XFER: flush pulse on beat 2 of a 4-beat packet from requester 3.
- IDLE next cycle;
- rr_ptr=0;
- no further writes from that packet until re-arbitration.
- Same stimulus with rst_n pulse in place of flush: busy=0 asynchronously.
